// File: rtl/const_sequencer.sv
// const_sequencer: fetches the immediate of a const instruction from a synchronous byte ROM,
// decodes LEB128 (i32/i64) or raw little-endian (f32/f64) bytes and pushes the value.
module const_sequencer #(
    parameter int ROM_ADDR = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          opcode,
    input  logic [ROM_ADDR-1:0] pc_in,
    output logic [ROM_ADDR-1:0] rom_addr,
    input  logic [7:0]          rom_data,
    output logic                push_valid,
    input  logic                push_ready,
    output logic [63:0]         push_data,
    output logic [1:0]          push_type,
    output logic [ROM_ADDR-1:0] pc_out,
    output logic                busy,
    output logic                done,
    output logic [3:0]          trap
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CAPT, S_EXT, S_PUSH} state_t;
    state_t              r_state;
    logic [ROM_ADDR-1:0] r_ptr;
    logic [1:0]          r_kind;
    logic [3:0]          r_cnt;
    logic [63:0]         r_acc;
    logic                r_sign;
    logic                w_op_ok;
    logic [3:0]          w_cnt_nx;
    logic                w_last;
    logic                w_ovl;
    logic                w_ovr;
    logic [6:0]          w_sh;
    logic [63:0]         w_byte;
    logic [63:0]         w_acc_nx;
    logic [6:0]          w_ext_sh;
    logic [63:0]         w_fill;
    logic [63:0]         w_val;
    logic [63:0]         w_res;
    // r_kind[1] selects raw float bytes, r_kind[0] selects the 64-bit variant
    always_comb begin
        w_op_ok  = opcode >= 8'h41 && opcode <= 8'h44;
        w_cnt_nx = r_cnt + 4'd1;
        w_last   = r_kind[1] ? (w_cnt_nx == (r_kind[0] ? 4'd8 : 4'd4)) : !rom_data[7];
        w_ovl    = !r_kind[1] && rom_data[7] && w_cnt_nx == (r_kind[0] ? 4'd10 : 4'd5);
        w_ovr    = !w_last && r_ptr == '1;
        w_sh     = r_kind[1] ? {r_cnt, 3'b000} : 7'(r_cnt) * 7'd7;
        w_byte   = r_kind[1] ? {56'd0, rom_data} : {57'd0, rom_data[6:0]};
        w_acc_nx = r_acc | (w_byte << w_sh);
        w_ext_sh = 7'(r_cnt) * 7'd7;
        w_fill   = (r_sign && !r_kind[1]) ? ~64'd0 << w_ext_sh : 64'd0;
        w_val    = r_acc | w_fill;
        w_res    = r_kind[0] ? w_val : {32'd0, w_val[31:0]};
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_kind     <= 2'd0;
            r_cnt      <= 4'd0;
            r_acc      <= 64'd0;
            r_sign     <= 1'b0;
            rom_addr   <= '0;
            push_valid <= 1'b0;
            push_data  <= 64'd0;
            push_type  <= 2'd0;
            pc_out     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trap       <= 4'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && w_op_ok) begin
                        r_state  <= S_FETCH;
                        busy     <= 1'b1;
                        trap     <= 4'd0;
                        r_kind   <= opcode[1:0] - 2'd1;
                        r_ptr    <= pc_in;
                        rom_addr <= pc_in;
                        r_cnt    <= 4'd0;
                        r_acc    <= 64'd0;
                    end else if (start) begin
                        trap <= 4'd1;
                    end
                end
                S_FETCH: r_state <= S_CAPT;
                S_CAPT: begin
                    r_acc  <= w_acc_nx;
                    r_ptr  <= r_ptr + 1'b1;
                    r_cnt  <= w_cnt_nx;
                    r_sign <= rom_data[6];
                    if (w_ovl || w_ovr) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        trap    <= w_ovl ? 4'd2 : 4'd3;
                    end else if (w_last) begin
                        r_state <= S_EXT;
                    end else begin
                        r_state  <= S_FETCH;
                        rom_addr <= r_ptr + 1'b1;
                    end
                end
                S_EXT: begin
                    push_data  <= w_res;
                    push_type  <= r_kind;
                    push_valid <= 1'b1;
                    r_state    <= S_PUSH;
                end
                S_PUSH: begin
                    if (push_ready) begin
                        push_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pc_out     <= r_ptr;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_const_sequencer.sv
// tb_const_sequencer: randomized and directed stimulus against a transaction-level model
// that predicts every output from the byte count and decoded value of each instruction.
module tb_const_sequencer;
    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  opcode;
    logic [7:0]  pc_in;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        push_valid;
    logic        push_ready;
    logic [63:0] push_data;
    logic [1:0]  push_type;
    logic [7:0]  pc_out;
    logic        busy;
    logic        done;
    logic [3:0]  trap;
    logic [7:0]  rom [256];
    int          vectors = 0;
    int          miscompares = 0;
    logic        cmp_en = 1'b0;
    logic        m_busy;
    logic        m_done;
    int          m_t;
    int          m_n;
    logic [3:0]  m_tc;
    logic [3:0]  m_trap;
    logic [63:0] m_val;
    logic [1:0]  m_ty;
    logic [7:0]  m_pc0;
    logic [7:0]  m_raddr;
    logic [7:0]  m_pcout;

    const_sequencer #(.ROM_ADDR(8)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .pc_in(pc_in),
        .rom_addr(rom_addr), .rom_data(rom_data), .push_valid(push_valid),
        .push_ready(push_ready), .push_data(push_data), .push_type(push_type),
        .pc_out(pc_out), .busy(busy), .done(done), .trap(trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decodes one instruction straight from the ROM contents: bytes consumed, trap, value.
    function automatic void decode(input logic [7:0] op, input logic [7:0] pc,
                                   output int n, output logic [3:0] tc, output logic [63:0] v);
        logic [79:0] acc;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lim;
        bit          raw;
        raw = op >= 8'h43;
        lim = op == 8'h41 ? 5 : op == 8'h42 ? 10 : op == 8'h43 ? 4 : 8;
        acc = '0;
        tc  = 4'd0;
        n   = lim;
        for (int i = 0; i < lim; i++) begin
            a = pc + 8'(i);
            b = rom[a];
            if (raw) acc[8*i +: 8] = b;
            else acc[7*i +: 7] = b[6:0];
            if (!raw && !b[7]) begin
                n = i + 1;
                if (b[6]) for (int j = 7 * (i + 1); j < 80; j++) acc[j] = 1'b1;
                break;
            end
            if (!raw && i == lim - 1) begin
                tc = 4'd2;
                n  = i + 1;
                break;
            end
            if (i < lim - 1 && a == 8'hFF) begin
                tc = 4'd3;
                n  = i + 1;
                break;
            end
        end
        v = (op == 8'h42 || op == 8'h44) ? acc[63:0] : {32'd0, acc[31:0]};
    endfunction

    function automatic logic exp_pv();
        return m_busy && m_tc == 4'd0 && m_t >= 2 * m_n + 1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_n = 0; m_tc = 4'd0; m_trap = 4'd0;
        m_val = 64'd0; m_ty = 2'd0; m_pc0 = 8'd0; m_raddr = 8'd0; m_pcout = 8'd0;
    endtask

    // Timeline after acceptance: fetch i at t=2i, capture at 2i+1, extend at 2n, push from 2n+1.
    task automatic model_update();
        if (!reset) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (m_busy) begin
            if (exp_pv() && push_ready) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_pcout = m_pc0 + 8'(m_n);
            end else begin
                m_t++;
                if (m_tc != 4'd0 && m_t == 2 * m_n) begin
                    m_busy = 1'b0;
                    m_trap = m_tc;
                end else if (m_t % 2 == 0 && m_t < 2 * m_n) begin
                    m_raddr = m_pc0 + 8'(m_t / 2);
                end
            end
        end else if (start) begin
            if (opcode >= 8'h41 && opcode <= 8'h44) begin
                decode(opcode, pc_in, m_n, m_tc, m_val);
                m_busy  = 1'b1;
                m_t     = 0;
                m_trap  = 4'd0;
                m_pc0   = pc_in;
                m_raddr = pc_in;
                m_ty    = 2'(opcode - 8'h41);
            end else begin
                m_trap = 4'd1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("push_valid", push_valid, exp_pv());
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("trap", trap, m_trap);
            chk("rom_addr", rom_addr, m_raddr);
            chk("pc_out", pc_out, m_pcout);
            if (exp_pv()) begin
                chk("push_data", push_data, m_val);
                chk("push_type", push_type, m_ty);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] pc);
        start = 1'b1; opcode = op; pc_in = pc;
        step();
        start = 1'b0;
    endtask

    task automatic to_valid(output int edges);
        edges = 0;
        while (!push_valid && edges < 40) begin
            step();
            edges++;
        end
        chk("valid_seen", push_valid, 1'b1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_busy && k < 200) begin
            step();
            k++;
        end
        chk("idle", busy, 1'b0);
    endtask

    task automatic prep(output logic [7:0] op, output logic [7:0] pc);
        int         lim;
        int         len;
        logic [7:0] b;
        op  = 8'h41 + 8'($urandom_range(0, 3));
        pc  = ($urandom_range(0, 7) == 0) ? 8'hF8 + 8'($urandom_range(0, 7)) : 8'($urandom);
        lim = op == 8'h41 ? 5 : op == 8'h42 ? 10 : op == 8'h43 ? 4 : 8;
        len = op >= 8'h43 ? lim : $urandom_range(1, lim + 1);
        for (int i = 0; i < lim; i++) begin
            b = 8'($urandom);
            if (op < 8'h43) b[7] = (i < len - 1);
            rom[pc + 8'(i)] = b;
        end
    endtask

    initial begin
        int          e;
        bit          seen;
        logic [7:0]  op;
        logic [7:0]  pc;
        int          n;
        logic [3:0]  tc;
        logic [63:0] v;
        reset = 1'b0; start = 1'b0; opcode = 8'd0; pc_in = 8'd0; push_ready = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = 8'd0;
        model_reset();
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_push_valid", push_valid, 1'b0);
        chk("rst_push_data", push_data, 64'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_trap", trap, 4'd0);
        chk("rst_rom_addr", rom_addr, 8'd0);
        reset = 1'b1;
        step();
        rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00; rom[4] = 8'hC0;
        issue(8'h43, 8'd1);
        to_valid(e);
        chk("f32_latency", e, 9);
        chk("f32_data", push_data, 64'h00000000C0000000);
        chk("f32_type", push_type, 2'd2);
        chk("f32_model", m_val, 64'h00000000C0000000);
        step();
        chk("f32_done", done, 1'b1);
        chk("f32_pc_out", pc_out, 8'd5);
        rom[10] = 8'h7F;
        issue(8'h41, 8'd10);
        to_valid(e);
        chk("i32_latency", e, 3);
        chk("i32_data", push_data, 64'h00000000FFFFFFFF);
        step();
        chk("i32_pc_out", pc_out, 8'd11);
        rom[20] = 8'hE5; rom[21] = 8'h8E; rom[22] = 8'h26;
        decode(8'h42, 8'd20, n, tc, v);
        chk("i64_model", v, 64'h0000000000098765);
        issue(8'h42, 8'd20);
        to_valid(e);
        chk("i64_latency", e, 7);
        chk("i64_data", push_data, 64'h0000000000098765);
        chk("i64_type", push_type, 2'd1);
        step();
        chk("i64_pc_out", pc_out, 8'd23);
        push_ready = 1'b0;
        issue(8'h41, 8'd10);
        to_valid(e);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_valid", push_valid, 1'b1);
            chk("bp_data", push_data, 64'h00000000FFFFFFFF);
            chk("bp_done", done, 1'b0);
        end
        push_ready = 1'b1;
        step();
        chk("bp_release_valid", push_valid, 1'b0);
        chk("bp_release_done", done, 1'b1);
        issue(8'h45, 8'd50);
        chk("badop_trap", trap, 4'd1);
        chk("badop_busy", busy, 1'b0);
        chk("badop_rom_addr", rom_addr, 8'd10);
        for (int i = 30; i < 35; i++) rom[i] = 8'h80;
        issue(8'h41, 8'd30);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            seen |= push_valid;
        end
        chk("ovl_trap", trap, 4'd2);
        chk("ovl_no_push", seen, 1'b0);
        rom[8'hFE] = 8'h80; rom[8'hFF] = 8'h80;
        issue(8'h42, 8'hFE);
        repeat (6) step();
        chk("ovr_trap", trap, 4'd3);
        for (int i = 40; i < 48; i++) rom[i] = 8'($urandom);
        issue(8'h44, 8'd40);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rom_addr", rom_addr, 8'd0);
        chk("mid_rst_trap", trap, 4'd0);
        chk("mid_rst_push_data", push_data, 64'd0);
        repeat (2) step();
        reset = 1'b1;
        issue(8'h43, 8'd1);
        to_valid(e);
        chk("post_rst_latency", e, 9);
        chk("post_rst_data", push_data, 64'h00000000C0000000);
        step();
        chk("post_rst_done", done, 1'b1);
        for (int c = 0; c < 4000; c++) begin
            push_ready = ($urandom_range(0, 2) != 0);
            if (!m_busy && $urandom_range(0, 2) == 0) begin
                prep(op, pc);
                start = 1'b1; opcode = op; pc_in = pc;
            end else begin
                start  = ($urandom_range(0, 5) == 0);
                opcode = 8'($urandom_range(8'h3F, 8'h46));
                pc_in  = 8'($urandom);
            end
            step();
        end
        start = 1'b0;
        push_ready = 1'b1;
        wait_idle();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/const_sequencer.md
CONST_SEQUENCER -- requirements
Module: const_sequencer

Interface
REQ-001 Parameter: ROM_ADDR, default 8, ROM address width in bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to decode one const instruction; sampled only in IDLE.
REQ-005 opcode  input  8  const opcode, valid with start: 0x41 i32, 0x42 i64, 0x43 f32, 0x44 f64.
REQ-006 pc_in  input  ROM_ADDR  address of first immediate byte, valid with start.
REQ-007 rom_addr  output  ROM_ADDR  byte address presented to synchronous ROM.
REQ-008 rom_data  input  8  ROM byte, valid the cycle after rom_addr is presented.
REQ-009 push_valid  output  1  assembled immediate available for the operand stack.
REQ-010 push_ready  input  1  stack accepts push_data this cycle.
REQ-011 push_data  output  64  assembled immediate.
REQ-012 push_type  output  2  0 i32, 1 i64, 2 f32, 3 f64.
REQ-013 pc_out  output  ROM_ADDR  address following the last consumed immediate byte.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after a completed push.
REQ-016 trap  output  4  0 none, 1 bad opcode, 2 LEB overlong, 3 ROM address overrun.

Function
REQ-017 States: IDLE, FETCH, CAPT, EXT, PUSH; IDLE->FETCH on start with a valid opcode.
REQ-018 FETCH: rom_addr = ptr; next state CAPT.
REQ-019 CAPT: capture rom_data, ptr increments; next state FETCH if more bytes are needed, else EXT.
REQ-020 EXT: sign-extend / finalize in one cycle; next state PUSH.
REQ-021 PUSH: push_valid high; at an edge with push_ready high -> IDLE, done=1 for the following cycle, pc_out=ptr.
REQ-022 Latency: push_valid first high 2n+1 edges after the accepting edge, n = immediate byte count (f32: 9 edges).
REQ-023 f32 immediate: 4 raw bytes, little-endian, into push_data[31:0]; push_data[63:32]=0.
REQ-024 f64 immediate: 8 raw bytes, little-endian, into push_data[63:0].
REQ-025 i32 immediate: signed LEB128, at most 5 bytes, sign-extended to 32 bits in [31:0]; [63:32]=0.
REQ-026 i64 immediate: signed LEB128, at most 10 bytes, sign-extended to 64 bits.
REQ-027 LEB decoding ends on the first byte with bit7=0; sign is bit6 of that byte.
REQ-028 Continuation bit set on byte 5 (i32) or byte 10 (i64) -> trap=2, IDLE, no push.
REQ-029 Opcode outside 0x41..0x44 with start -> trap=1 at the next edge, stays IDLE, no ROM access, no push.
REQ-030 Capturing a byte at the all-ones address while more bytes are required -> trap=3, IDLE, no push.
REQ-031 trap holds its value until the next accepted start, which clears it to 0.
REQ-032 start while busy is ignored.
REQ-033 push_data, push_type and push_valid stay stable while push_ready is low.
REQ-034 rom_addr holds its last value outside FETCH.

Reset
REQ-035 reset low -> IDLE immediately; push_valid, push_data, push_type, rom_addr, pc_out, busy, done and trap all 0.
REQ-036 reset asserted mid-operation aborts the operation with no push and no done pulse.

Verification
REQ-037 f32: opcode 0x43, pc_in=1, ROM[1..4]=00 00 00 C0, push_ready=1 -> push_data=0x00000000C0000000, push_type=2, push_valid 9 edges after start, pc_out=5, done pulse.
REQ-038 i32: ROM byte 0x7F -> push_data=0x00000000FFFFFFFF, push_valid 3 edges after start, pc_out=pc_in+1.
REQ-039 i64: ROM E5 8E 26 -> push_data=0x0000000000098765 (624485), pc_out=pc_in+3.
REQ-040 Backpressure: push_ready low for 4 cycles in PUSH -> outputs stable; done only after the edge with push_ready=1.
REQ-041 Errors: opcode 0x45 -> trap=1, rom_addr unchanged; i32 with 80 80 80 80 80 -> trap=2, no push_valid.
REQ-042 Reset low during FETCH of an f64 -> all outputs 0 at once; a new f32 start after release completes normally.
